sync_debounce: RTL and testbench

//   Multi-channel input conditioner for asynchronous level inputs (keys, switches, ext. strobes).

---
 rtl/sync_debounce.sv | 158 +++++++++++++++
 tb/tb_sync_debounce.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// ---------------------------------------------------------------------------
// sync_debounce
//
// Multi-channel input conditioner for asynchronous level inputs such as keys,
// switches and external strobes. Each channel passes through a SYNC_NUM-deep
// flop synchroniser and then a debounce counter. The debounced level only
// changes once the synchronised input has disagreed with it for DEBOUNCE_CYC
// consecutive cycles. One-cycle edge pulses are produced when the debounced
// level changes.
//
// Parameters
//   WIDTH         number of independent channels (>= 1)
//   SYNC_NUM      synchroniser depth in flops (2..4)
//   DEBOUNCE_CYC  consecutive disagreeing cycles before dout updates (>= 1)
//   RST_VAL       reset value of every synchroniser flop and of dout
//
// Ports
//   clk    in   1      system clock, all logic on posedge
//   rst    in   1      synchronous reset, active-high
//   din    in   WIDTH  asynchronous raw inputs
//   dout   out  WIDTH  debounced, clk-synchronous level
//   rise   out  WIDTH  1-cycle pulse when dout[i] goes 0->1
//   fall   out  WIDTH  1-cycle pulse when dout[i] goes 1->0
//   busy   out  WIDTH  1 while the channel counter is non-zero
//
// Build option
//   SYNC_DEBOUNCE_EDGE_EN  defined   : rise/fall pulses are generated.
//                          undefined : no edge logic, rise/fall tied to 0.
//   dout, busy and latency are the same in both builds.
//
// Latency: with din stable before edge 1, dout changes at edge
// SYNC_NUM + DEBOUNCE_CYC.
// ---------------------------------------------------------------------------
module sync_debounce #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned SYNC_NUM     = 2,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter logic        RST_VAL      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    // Count value at which the next disagreeing cycle commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    // -----------------------------------------------------------------------
    // Synchroniser: stage k holds all channels. Pure flop chain, no logic
    // between stages; only the last stage feeds the debounce logic.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [SYNC_NUM];
    logic [WIDTH-1:0] ss;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // stage samples its predecessor's pre-edge value; blocking would collapse
    // the chain into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(SYNC_NUM); k++) begin
                sync_q[k] <= {WIDTH{RST_VAL}};
            end
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < int'(SYNC_NUM); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign ss = sync_q[SYNC_NUM-1];

    // -----------------------------------------------------------------------
    // Debounce: one counter per channel counts consecutive cycles where the
    // synchronised level disagrees with dout. Any agreeing cycle clears it,
    // so a disagreement has to persist unbroken for DEBOUNCE_CYC cycles.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (ss[i] == dout_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // Disagreement has lasted the full window: commit the level.
                dout_d[i] = ss[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // NOTE: the counters are reset along with dout; a count surviving reset
    // would shorten the first debounce window after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= {WIDTH{RST_VAL}};
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            dout_q <= dout_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign dout = dout_q;

    always_comb begin
        busy = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    // -----------------------------------------------------------------------
    // Edge pulses: registered from the dout transition so they line up with
    // the cycle in which dout shows the new level. A channel changes dout in
    // one direction per edge, so rise and fall are mutually exclusive.
    // -----------------------------------------------------------------------
`ifdef SYNC_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= dout_d & ~dout_q;
            fall_q <= ~dout_d & dout_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    // Ports stay in place so the interface is identical in both builds.
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// ---------------------------------------------------------------------------
// tb_sync_debounce
//
// Drives two instances from the same inputs:
//   dut_a : WIDTH=4, SYNC_NUM=2, DEBOUNCE_CYC=8, RST_VAL=0
//   dut_b : WIDTH=4, SYNC_NUM=3, DEBOUNCE_CYC=1, RST_VAL=1
// A reference model predicts every output each cycle. The model keeps the
// raw input history and a sliding window of the last DEBOUNCE_CYC
// synchronised samples; dout flips when every sample in the window disagrees
// with it. Edge expectations follow SYNC_DEBOUNCE_EDGE_EN.
// ---------------------------------------------------------------------------
module tb_sync_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic [3:0] dout_a, rise_a, fall_a, busy_a;
    logic [3:0] dout_b, rise_b, fall_b, busy_b;

    always #5 clk = ~clk;

    sync_debounce #(
        .WIDTH(4), .SYNC_NUM(2), .DEBOUNCE_CYC(8), .RST_VAL(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .din(din),
        .dout(dout_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
    );

    sync_debounce #(
        .WIDTH(4), .SYNC_NUM(3), .DEBOUNCE_CYC(1), .RST_VAL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .din(din),
        .dout(dout_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
    );

    // ---------------- scoreboard counters ----------------
    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int rise_cnt [4];
    int fall_cnt [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Index 0 = dut_a, 1 = dut_b.
    logic [3:0] m_hist [2][4];  // raw din samples, [0] = most recent edge
    logic [3:0] m_win  [2][8];  // synchronised samples, [0] = most recent
    logic [3:0] m_dout [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    logic [3:0] m_busy [2];

    task automatic model_step(input int k, input int ns, input int nd,
                              input logic rv, input logic r, input logic [3:0] d);
        logic [3:0] ss;
        logic       all_differ;
        if (r) begin
            for (int j = 0; j < 4; j++) m_hist[k][j] = {4{rv}};
            for (int j = 0; j < 8; j++) m_win[k][j]  = {4{rv}};
            m_dout[k] = {4{rv}};
            m_rise[k] = '0;
            m_fall[k] = '0;
            m_busy[k] = '0;
        end else begin
            // Level seen at the synchroniser output before this edge: the
            // input as sampled ns edges ago.
            ss = m_hist[k][ns-1];
            for (int j = ns - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
            m_hist[k][0] = d;
            for (int j = nd - 1; j > 0; j--) m_win[k][j] = m_win[k][j-1];
            m_win[k][0] = ss;
            m_rise[k] = '0;
            m_fall[k] = '0;
            m_busy[k] = '0;
            for (int b = 0; b < 4; b++) begin
                all_differ = 1'b1;
                for (int j = 0; j < nd; j++) begin
                    if (m_win[k][j][b] == m_dout[k][b]) all_differ = 1'b0;
                end
                if (all_differ) begin
                    m_dout[k][b] = ss[b];
`ifdef SYNC_DEBOUNCE_EDGE_EN
                    m_rise[k][b] = ss[b];
                    m_fall[k][b] = ~ss[b];
`endif
                end else begin
                    m_busy[k][b] = (ss[b] != m_dout[k][b]);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 2, 8, 1'b0, rst, din);
        model_step(1, 3, 1, 1'b1, rst, din);
    end

    // ---------------- per-cycle compare ----------------
    task automatic tick();
        @(negedge clk);
        cyc++;
        check("a_dout", {28'd0, dout_a}, {28'd0, m_dout[0]});
        check("a_rise", {28'd0, rise_a}, {28'd0, m_rise[0]});
        check("a_fall", {28'd0, fall_a}, {28'd0, m_fall[0]});
        check("a_busy", {28'd0, busy_a}, {28'd0, m_busy[0]});
        check("b_dout", {28'd0, dout_b}, {28'd0, m_dout[1]});
        check("b_rise", {28'd0, rise_b}, {28'd0, m_rise[1]});
        check("b_fall", {28'd0, fall_b}, {28'd0, m_fall[1]});
        check("b_busy", {28'd0, busy_b}, {28'd0, m_busy[1]});
        for (int b = 0; b < 4; b++) begin
            if (rise_a[b]) rise_cnt[b]++;
            if (fall_a[b]) fall_cnt[b]++;
        end
    endtask

    // Counts edges until (dout_a & mask) == val; bounded so a stuck DUT fails.
    task automatic wait_dout(input string tag, input logic [3:0] mask,
                             input logic [3:0] val, input int exp_n);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (((dout_a & mask) != val) && (n < 40));
        check(tag, n, exp_n);
    endtask

    task automatic clear_edge_counts();
        for (int b = 0; b < 4; b++) begin
            rise_cnt[b] = 0;
            fall_cnt[b] = 0;
        end
    endtask

    int exp_edges;
    int p;
    logic [3:0] flip;

    initial begin
`ifdef SYNC_DEBOUNCE_EDGE_EN
        exp_edges = 1;
`else
        exp_edges = 0;
`endif
        clear_edge_counts();

        // 1. reset with all inputs high, then release
        rst = 1'b1;
        din = 4'hF;
        repeat (3) tick();
        rst = 1'b0;
        wait_dout("t1_latency", 4'hF, 4'hF, 10);

        // 2. all low, settle, then single rising channel
        din = 4'h0;
        wait_dout("t2_fall_latency", 4'hF, 4'h0, 10);
        repeat (4) tick();
        clear_edge_counts();
        din[0] = 1'b1;
        wait_dout("t2_latency", 4'h1, 4'h1, 10);
        tick();
        check("t2_rise_count", rise_cnt[0], exp_edges);

        // 3. short pulse must be filtered
        clear_edge_counts();
        din[1] = 1'b1;
        repeat (5) tick();
        din[1] = 1'b0;
        repeat (12) tick();
        check("t3_dout", {31'd0, dout_a[1]}, 32'd0);
        check("t3_busy", {31'd0, busy_a[1]}, 32'd0);
        check("t3_edges", rise_cnt[1] + fall_cnt[1], 0);

        // 4. bounce every 3 cycles, then held high
        clear_edge_counts();
        for (int c = 0; c < 30; c++) begin
            if (c % 3 == 0) din[2] = ~din[2];
            tick();
        end
        din[2] = 1'b1;
        wait_dout("t4_latency", 4'h4, 4'h4, 10);
        repeat (5) tick();
        check("t4_rise_count", rise_cnt[2], exp_edges);
        check("t4_fall_count", fall_cnt[2], 0);

        // 5. reset mid-count restarts the count
        din[3] = 1'b1;
        repeat (6) tick();
        check("t5_pre_reset", {31'd0, dout_a[3]}, 32'd0);
        rst = 1'b1;
        tick();
        check("t5_in_reset", {31'd0, dout_a[3]}, 32'd0);
        rst = 1'b0;
        wait_dout("t5_latency", 4'h8, 4'h8, 10);

        // 6. randomized: bouncy, mixed and calm phases with rare resets
        for (int c = 0; c < 3000; c++) begin
            p = (c < 1000) ? 4 : ((c < 2000) ? 9 : 24);
            flip = '0;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(p - 1, 0) == 0) flip[b] = 1'b1;
            end
            din = din ^ flip;
            rst = ($urandom_range(399, 0) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
